serial_parity_checker: RTL
==========================

# serial_parity_checker

Receive-side counterpart of the single-bit XOR parity path. The block accepts a bit-serial frame (WIDTH data bits, LSB first, then one parity bit), deserializes it, and checks parity with a running XOR. It then presents the parallel word together with a parity-error flag, and keeps a saturating count of failed frames. It sits at the far end of a serial link, after the transmit-side XOR parity generator.

## Interface
- WIDTH, 8, number of data bits per frame (2..32)
- ODD, 0, parity sense: 0 = even (XOR of data+parity must be 0), 1 = odd (must be 1)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- bit_in  input  1  serial data/parity bit
- bit_valid  input  1  bit_in is sampled on this cycle
- sof  input  1  start of frame; only meaningful with bit_valid=1; marks bit_in as data bit 0
- data_out  output  WIDTH  last completed frame's data word
- data_valid  output  1  one-cycle pulse: data_out/parity_err updated
- parity_err  output  1  parity result of last completed frame (1 = mismatch)
- frame_abort  output  1  one-cycle pulse: frame in progress discarded by a new sof
- busy  output  1  frame in progress (state != IDLE)
- err_count  output  8  saturating count of frames with parity_err=1

## Operation
- States: IDLE, DATA, PARITY.
- IDLE: bit_valid=1 with sof=1 -> store bit_in as data bit 0, parity accumulator = bit_in, bit counter = 1, go to DATA. Handle WIDTH=1 per the counter rule. bit_valid without sof is ignored.
- DATA: each bit_valid=1 with sof=0 stores bit_in at position counter, XORs it into the accumulator, and increments counter. When the bit at position WIDTH-1 is stored, go to PARITY.
- PARITY: bit_valid=1 with sof=0 -> final = accumulator XOR bit_in. Set parity_err = final XOR ODD, load data_out from the shift register, pulse data_valid, and return to IDLE.
- bit_valid=0 in any state: hold; gaps of any length are allowed between bits.
- sof=1 with bit_valid=1 in DATA or PARITY: discard the partial frame and pulse frame_abort. The bit is taken as data bit 0 of a new frame, and the state goes to DATA. data_out, parity_err and err_count are unchanged.
- err_count increments by 1 on each data_valid with parity_err=1 and saturates at 255. It is cleared only by rst.
- data_out and parity_err hold their values between data_valid pulses.

## Timing
- All outputs are registered.
- Reset values: data_out=0, data_valid=0, parity_err=0, frame_abort=0, busy=0, err_count=0, state IDLE, counter 0.
- rst has priority over all inputs. Reset mid-frame drops the frame with no data_valid and no frame_abort.
- Latency: data_valid, data_out and parity_err are updated in the cycle after the parity bit is sampled. err_count updates in the same cycle as data_valid.
- frame_abort asserts in the cycle after the aborting sof is sampled.
- busy goes high in the cycle after the sof bit is sampled and low in the same cycle data_valid asserts.
- Minimum frame length is WIDTH+1 consecutive valid cycles.
- Back-to-back frames: sof may arrive on the cycle immediately after the parity bit, i.e. the same cycle data_valid is high. No bubble is required.
- sof=1 with bit_valid=0 is ignored.

## Test plan
- Even, clean frame: WIDTH=8, ODD=0. Send 0xA5 LSB first (1,0,1,0,0,1,0,1) on 9 consecutive valid cycles, first bit with sof, then parity 0 -> data_out=0xA5, parity_err=0, data_valid high 1 cycle, err_count=0.
- Parity error: same frame with parity bit 1 -> data_out=0xA5, parity_err=1, err_count=1.
- Gaps: send 0x3C with random bit_valid=0 gaps of 0-5 cycles between bits, parity 0 -> data_out=0x3C, parity_err=0. busy stays high throughout the gaps.
- Abort and back-to-back: send 4 bits of a frame, then sof with a new frame 0xFF with parity 0 -> frame_abort pulses once and data_out=0xFF. Immediately follow with sof of 0x01 with parity 1 -> second data_valid with data_out=0x01, parity_err=0.
- Saturation and reset: send 260 frames with a wrong parity bit -> err_count stops at 255. Assert rst mid-frame -> all outputs return to 0, and no data_valid appears for the dropped frame.
- Odd sense: ODD=1. Send 0x01 with parity 0 -> parity_err=0. Send 0x01 with parity 1 -> parity_err=1.

Source files
------------

// File: rtl/serial_parity_checker.sv
// Receive-side serial parity checker: deserializes WIDTH data bits (LSB first)
// plus one parity bit, flags parity mismatches and counts failed frames.
module serial_parity_checker #(
  parameter int WIDTH = 8,
  parameter int ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_abort,
  output logic             busy,
  output logic [7:0]       err_count,
  output logic [1:0]       state_dbg
);

  // Handshake: bit_valid qualifies bit_in and sof on the same cycle. There is
  // no backpressure; every valid bit is consumed, and sof without bit_valid
  // carries no meaning.

  localparam int            CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
  localparam logic          ODD_B = (ODD != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  // A one-bit frame has no further data bits, so it goes straight to parity.
  localparam state_t START = (WIDTH == 1) ? PARITY : DATA;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] shreg;
  logic            acc;
  logic            perr;

  assign perr      = acc ^ bit_in ^ ODD_B;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      acc         <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      data_valid  <= 1'b0;
      frame_abort <= 1'b0;
      if (bit_valid) begin
        if (sof) begin
          // A sof always restarts; a frame already in progress is dropped.
          if (state != IDLE) frame_abort <= 1'b1;
          shreg <= WIDTH'(bit_in);
          acc   <= bit_in;
          cnt   <= CW'(1);
          state <= START;
          busy  <= 1'b1;
        end else begin
          unique case (state)
            IDLE: ;
            DATA: begin
              shreg <= shreg | (WIDTH'(bit_in) << cnt);
              acc   <= acc ^ bit_in;
              cnt   <= cnt + CW'(1);
              if (cnt == LAST) state <= PARITY;
            end
            PARITY: begin
              data_out   <= shreg;
              parity_err <= perr;
              data_valid <= 1'b1;
              if (perr && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
